pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 85 ++++++++
 tb/tb_pipe_stage_skid.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubble
module pipe_stage_skid #(
  parameter int PAYLOAD_W   = 142,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   bubble,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAYLOAD_W-1:0]   out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  // in_ready comes straight from state so upstream never sees a path through out_ready
  assign in_ready  = (state_q != FULL) & ~bubble;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // next-state and entry contents; flush wipes both entries and drops any simultaneous input
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
        ONE: if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          main_d  = '0;
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end
        FULL: if (out_fire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end
  // state, payload and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      occupancy <= state_d == FULL ? 2'd2 : state_d == ONE ? 2'd1 : 2'd0;
    end
  end
  // saturating count of downstream stall cycles; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random stimulus against a queue-based reference model
module tb_pipe_stage_skid;
  localparam int W  = 142;
  localparam int SW = 4;
  logic clk = 0, rst, flush, bubble, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [SW-1:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  int stalls = 0;

  pipe_stage_skid #(.PAYLOAD_W(W), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(1));
    return r;
  endfunction

  task automatic chk_outs(input string tag);
    int sat;
    sat = stalls > (2**SW - 1) ? 2**SW - 1 : stalls;
    chk({tag, ".out_valid"}, 160'(out_valid), 160'(q.size() > 0));
    chk({tag, ".out_data"},  160'(out_data),  q.size() > 0 ? 160'(q[0]) : 160'(0));
    chk({tag, ".occupancy"}, 160'(occupancy), 160'(q.size()));
    chk({tag, ".stall_cnt"}, 160'(stall_cnt), 160'(sat));
  endtask

  task automatic cyc(input string tag, input logic f, input logic b, input logic iv,
                     input logic [W-1:0] d, input logic orr);
    logic exp_ready, inf, outf;
    flush = f; bubble = b; in_valid = iv; in_data = d; out_ready = orr;
    #1;
    exp_ready = q.size() < 2 && !b;
    chk({tag, ".in_ready"}, 160'(in_ready), 160'(exp_ready));
    inf  = iv && exp_ready;
    outf = q.size() > 0 && orr;
    if (q.size() > 0 && !orr) stalls++;
    @(posedge clk);
    #1;
    if (f) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(d);
    end
    chk_outs(tag);
  endtask

  initial begin
    rst = 1; flush = 0; bubble = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("reset.in_ready", 160'(in_ready), 160'(1));
    chk_outs("reset");
    for (int i = 1; i <= 4; i++) cyc("stream", 0, 0, 1, W'(i), 1);
    cyc("stream_drain", 0, 0, 0, W'(0), 1);
    cyc("bp_a", 0, 0, 1, W'(5), 0);
    cyc("bp_b", 0, 0, 1, W'(6), 0);
    cyc("bp_full", 0, 0, 1, W'(9), 0);
    repeat (3) cyc("bp_release", 0, 0, 0, W'(0), 1);
    cyc("fl_a", 0, 0, 1, W'(10), 0);
    cyc("fl_b", 0, 0, 1, W'(11), 0);
    cyc("flush_full", 1, 0, 1, W'(7), 0);
    cyc("after_flush", 0, 0, 0, W'(0), 0);
    cyc("bub_load", 0, 0, 1, W'(8), 0);
    cyc("bubble1", 0, 1, 1, W'(12), 1);
    cyc("bubble2", 0, 1, 1, W'(12), 1);
    cyc("bub_accept", 0, 0, 1, W'(13), 1);
    cyc("bub_drain", 0, 0, 0, W'(0), 1);
    cyc("sat_load", 0, 0, 1, W'(3), 0);
    repeat (20) cyc("saturate", 0, 0, 0, W'(0), 0);
    chk("sat_value", 160'(stall_cnt), 160'(15));
    cyc("flush_bubble", 1, 1, 1, W'(14), 1);
    for (int i = 0; i < 400; i++)
      cyc("random", 1'($urandom_range(19) == 0), 1'($urandom_range(4) == 0),
          1'($urandom_range(1)), rnd(), 1'($urandom_range(2) != 0));
    cyc("ar_flush", 1, 0, 0, W'(0), 0);
    cyc("ar_a", 0, 0, 1, rnd(), 0);
    cyc("ar_b", 0, 0, 1, rnd(), 0);
    chk("ar_full", 160'(occupancy), 160'(2));
    #1 rst = 1;
    #1;
    q.delete();
    stalls = 0;
    chk_outs("async_reset");
    rst = 0;
    #1;
    cyc("post_reset", 0, 0, 1, W'(15), 1);
    cyc("post_reset2", 0, 0, 0, W'(0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
